// File: rtl/lane_skew_pkg.sv
// rtl/lane_skew_pkg.sv - shared constants and default-config helpers for the lane skew emulator
// Purpose: ring-depth helper, zero-fill constant and reset-default functions
//          (identity lane map, per-lane default delay j mod depth).
package lane_skew_pkg;

    // Blocks emitted while a lane has not yet seen enough valids for its delay
    localparam logic ZERO_FILL_BIT = 1'b0;

    function automatic int ring_depth(input int nb_delay);
        return 1 << nb_delay;
    endfunction

    function automatic int identity_lane(input int lane);
        return lane;
    endfunction

    function automatic int default_delay(input int lane, input int nb_delay);
        return lane % ring_depth(nb_delay);
    endfunction

endpackage

// File: rtl/lane_delay_ring.sv
// rtl/lane_delay_ring.sv - single-write/single-read per-lane block delay ring
// Purpose: holds the last 2**NB_ADDR blocks of one lane; asynchronous read so the
//          top can read the entry being replaced in the same cycle (read-before-write).
// Ports:
//   i_clock    clock
//   i_wr_en    write strobe (one block per advance)
//   i_wr_ptr   write address
//   i_rd_addr  read address
//   i_wr_data  block to store
//   o_rd_data  block at i_rd_addr (pre-write contents)
module lane_delay_ring
    import lane_skew_pkg::*;
#(
    parameter int NB_DATA = 66,
    parameter int NB_ADDR = 5
) (
    input  logic               i_clock,
    input  logic               i_wr_en,
    input  logic [NB_ADDR-1:0] i_wr_ptr,
    input  logic [NB_ADDR-1:0] i_rd_addr,
    input  logic [NB_DATA-1:0] i_wr_data,
    output logic [NB_DATA-1:0] o_rd_data
);

    localparam int DEPTH = ring_depth(NB_ADDR);

    // Not reset: stale contents are masked by the top-level fill counter
    logic [NB_DATA-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clock) begin
        if (i_wr_en) begin
            r_mem[i_wr_ptr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/lane_skew_emulator.sv
// rtl/lane_skew_emulator.sv - runtime-programmable per-lane skew and lane-reorder emulator
// Purpose: delays each input lane by a programmable number of blocks, permutes lanes
//          onto the outputs, zero-fills during warm-up and rejects illegal lane maps.
// Ports:
//   i_clock, i_reset      clock, synchronous active-high reset
//   i_enable, i_valid     block advances when both are high
//   i_data                input blocks, lane 0 in MSB slice
//   i_delay_cfg           staged per-input-lane delay (blocks), lane 0 in MSB slice
//   i_lane_map            staged map, slice k = source input lane of output lane k
//   i_cfg_load            pulse: validate and apply staged config
//   o_data, o_valid       registered skewed/reordered blocks and strobe
//   o_cfg_busy            some active lane still zero-filling
//   o_lane_map_err        sticky: last load was rejected
module lane_skew_emulator
    import lane_skew_pkg::*;
#(
    parameter int NB_DATA_CODED = 66,
    parameter int N_LANES       = 20,
    parameter int NB_DELAY      = 5,
    parameter int NB_LANE_ID    = 5
) (
    input  logic                              i_clock,
    input  logic                              i_reset,
    input  logic                              i_enable,
    input  logic                              i_valid,
    input  logic [NB_DATA_CODED*N_LANES-1:0]  i_data,
    input  logic [NB_DELAY*N_LANES-1:0]       i_delay_cfg,
    input  logic [NB_LANE_ID*N_LANES-1:0]     i_lane_map,
    input  logic                              i_cfg_load,
    output logic [NB_DATA_CODED*N_LANES-1:0]  o_data,
    output logic                              o_valid,
    output logic                              o_cfg_busy,
    output logic                              o_lane_map_err
);

    localparam int                  DEPTH    = ring_depth(NB_DELAY);
    localparam logic [NB_DELAY-1:0] FILL_MAX = NB_DELAY'(DEPTH - 1);

    logic                             r_valid, r_busy, r_map_err;
    logic [NB_DATA_CODED*N_LANES-1:0] r_data;
    logic [NB_DELAY-1:0]              r_wr_ptr, r_fill_cnt;
    logic [NB_DELAY-1:0]              r_delay [N_LANES];
    logic [NB_LANE_ID-1:0]            r_map   [N_LANES];

    logic                             w_adv, w_map_illegal, w_cfg_apply;
    logic [NB_DATA_CODED-1:0]         w_in  [N_LANES];
    logic [NB_DATA_CODED-1:0]         w_rd  [N_LANES];
    logic [NB_DATA_CODED-1:0]         w_sel [N_LANES];
    logic [NB_DATA_CODED*N_LANES-1:0] w_out;
    logic [NB_DELAY-1:0]              w_cfg_delay  [N_LANES];
    logic [NB_LANE_ID-1:0]            w_cfg_map    [N_LANES];
    logic [NB_DELAY-1:0]              w_def_delay  [N_LANES];
    logic [NB_LANE_ID-1:0]            w_def_map    [N_LANES];
    logic [NB_DELAY-1:0]              w_delay_next [N_LANES];
    logic [NB_DELAY-1:0]              w_fill_next, w_max_next, w_max_def;

    assign w_adv       = i_enable & i_valid;
    assign w_cfg_apply = i_cfg_load & ~w_map_illegal;

    for (genvar j = 0; j < N_LANES; j++) begin : g_lane
        localparam int SL = N_LANES - 1 - j;

        assign w_in[j]        = i_data[SL*NB_DATA_CODED +: NB_DATA_CODED];
        assign w_cfg_delay[j] = i_delay_cfg[SL*NB_DELAY +: NB_DELAY];
        assign w_cfg_map[j]   = i_lane_map[SL*NB_LANE_ID +: NB_LANE_ID];
        assign w_def_delay[j] = NB_DELAY'(default_delay(j, NB_DELAY));
        assign w_def_map[j]   = NB_LANE_ID'(identity_lane(j));
        assign w_out[SL*NB_DATA_CODED +: NB_DATA_CODED] = w_sel[j];

        // Ring j is only ever read at its own lane's delay, so the read address
        // is per input lane; the crossbar below picks among ring outputs.
        lane_delay_ring #(
            .NB_DATA (NB_DATA_CODED),
            .NB_ADDR (NB_DELAY)
        ) u_ring (
            .i_clock   (i_clock),
            .i_wr_en   (w_adv),
            .i_wr_ptr  (r_wr_ptr),
            .i_rd_addr (r_wr_ptr - r_delay[j]),
            .i_wr_data (w_in[j]),
            .o_rd_data (w_rd[j])
        );
    end

    // Output crossbar: zero delay bypasses the ring, warm-up emits zero blocks
    always_comb begin
        for (int k = 0; k < N_LANES; k++) begin
            w_sel[k] = w_rd[r_map[k]];
            if (r_delay[r_map[k]] == '0) begin
                w_sel[k] = w_in[r_map[k]];
            end else if (r_fill_cnt < r_delay[r_map[k]]) begin
                w_sel[k] = {NB_DATA_CODED{ZERO_FILL_BIT}};
            end
        end
    end

    // A legal map is a permutation: every entry in range and no repeats
    always_comb begin
        w_map_illegal = 1'b0;
        for (int k = 0; k < N_LANES; k++) begin
            if (32'(w_cfg_map[k]) >= N_LANES) begin
                w_map_illegal = 1'b1;
            end
            for (int m = k + 1; m < N_LANES; m++) begin
                if (w_cfg_map[k] == w_cfg_map[m]) begin
                    w_map_illegal = 1'b1;
                end
            end
        end
    end

    // Load wins over the same-cycle fill increment; the current block already
    // used the old config through w_sel.
    always_comb begin
        w_fill_next = r_fill_cnt;
        if (w_adv && (r_fill_cnt != FILL_MAX)) begin
            w_fill_next = r_fill_cnt + 1'b1;
        end
        if (w_cfg_apply) begin
            w_fill_next = '0;
        end
        w_max_next = '0;
        w_max_def  = '0;
        for (int j = 0; j < N_LANES; j++) begin
            w_delay_next[j] = w_cfg_apply ? w_cfg_delay[j] : r_delay[j];
            if (w_delay_next[j] > w_max_next) begin
                w_max_next = w_delay_next[j];
            end
            if (w_def_delay[j] > w_max_def) begin
                w_max_def = w_def_delay[j];
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_wr_ptr   <= '0;
            r_fill_cnt <= '0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_map_err  <= 1'b0;
            r_busy     <= (w_max_def != '0);
            for (int j = 0; j < N_LANES; j++) begin
                r_delay[j] <= w_def_delay[j];
                r_map[j]   <= w_def_map[j];
            end
        end else begin
            r_valid    <= w_adv;
            r_fill_cnt <= w_fill_next;
            r_busy     <= (w_fill_next < w_max_next);
            if (w_adv) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                r_data   <= w_out;
            end
            if (i_cfg_load) begin
                r_map_err <= w_map_illegal;
            end
            for (int j = 0; j < N_LANES; j++) begin
                r_delay[j] <= w_delay_next[j];
                if (w_cfg_apply) begin
                    r_map[j] <= w_cfg_map[j];
                end
            end
        end
    end

    assign o_data         = r_data;
    assign o_valid        = r_valid;
    assign o_cfg_busy     = r_busy;
    assign o_lane_map_err = r_map_err;

endmodule

// File: tb/tb_lane_skew_emulator.sv
// tb/tb_lane_skew_emulator.sv - self-checking bench for lane_skew_emulator
module tb_lane_skew_emulator;

    localparam int NBD  = 66;
    localparam int NL   = 20;
    localparam int ND   = 5;
    localparam int NI   = 5;
    localparam int W    = NBD * NL;
    localparam int HMAX = 1024;

    logic            i_clock = 1'b0;
    logic            i_reset, i_enable, i_valid, i_cfg_load;
    logic [W-1:0]    i_data;
    logic [ND*NL-1:0] i_delay_cfg;
    logic [NI*NL-1:0] i_lane_map;
    logic [W-1:0]    o_data;
    logic            o_valid, o_cfg_busy, o_lane_map_err;

    int tests = 0;
    int fails = 0;

    // Staged config driven onto the pins, and the model's active config
    int cfg_delay [NL];
    int cfg_map   [NL];
    int m_delay   [NL];
    int m_map     [NL];
    int m_fill;
    int hcnt;
    logic [W-1:0] hist [HMAX];
    logic [W-1:0] exp_data, last_in;
    logic         exp_valid, exp_busy, exp_err;

    lane_skew_emulator #(
        .NB_DATA_CODED (NBD),
        .N_LANES       (NL),
        .NB_DELAY      (ND),
        .NB_LANE_ID    (NI)
    ) dut (
        .i_clock        (i_clock),
        .i_reset        (i_reset),
        .i_enable       (i_enable),
        .i_valid        (i_valid),
        .i_data         (i_data),
        .i_delay_cfg    (i_delay_cfg),
        .i_lane_map     (i_lane_map),
        .i_cfg_load     (i_cfg_load),
        .o_data         (o_data),
        .o_valid        (o_valid),
        .o_cfg_busy     (o_cfg_busy),
        .o_lane_map_err (o_lane_map_err)
    );

    always #5 i_clock = ~i_clock;

    function automatic logic [NBD-1:0] lane_of(input logic [W-1:0] v, input int k);
        return v[(NL-1-k)*NBD +: NBD];
    endfunction

    function automatic int diff_lane(input logic [W-1:0] a, input logic [W-1:0] b);
        for (int k = 0; k < NL; k++) begin
            if (lane_of(a, k) !== lane_of(b, k)) return k;
        end
        return 0;
    endfunction

    function automatic int max_delay();
        int mx = 0;
        for (int j = 0; j < NL; j++) if (m_delay[j] > mx) mx = m_delay[j];
        return mx;
    endfunction

    task automatic set_model_defaults();
        for (int j = 0; j < NL; j++) begin
            m_map[j]   = j;
            m_delay[j] = j % 32;
        end
        m_fill    = 0;
        hcnt      = 0;
        exp_data  = '0;
        exp_valid = 1'b0;
        exp_err   = 1'b0;
        exp_busy  = (max_delay() > 0);
    endtask

    task automatic cfg_random_perm();
        int t, r;
        for (int j = 0; j < NL; j++) begin
            cfg_map[j]   = j;
            cfg_delay[j] = $urandom_range(0, 31);
        end
        for (int j = NL - 1; j > 0; j--) begin
            r = $urandom_range(0, j);
            t = cfg_map[j]; cfg_map[j] = cfg_map[r]; cfg_map[r] = t;
        end
    endtask

    // One clock: drive inputs, let the DUT sample, advance the reference model
    // from the specification's rules (history of whole input words since reset).
    task automatic cycle(input bit en, input bit vld, input bit load);
        bit legal;
        bit seen [32];
        int s, d;
        for (int k = 0; k < NL; k++) begin
            i_data[(NL-1-k)*NBD +: NBD] = {$urandom, $urandom, 2'($urandom)};
            i_delay_cfg[(NL-1-k)*ND +: ND] = ND'(cfg_delay[k]);
            i_lane_map[(NL-1-k)*NI +: NI]  = NI'(cfg_map[k]);
        end
        i_enable   = en;
        i_valid    = vld;
        i_cfg_load = load;
        @(posedge i_clock);
        last_in   = i_data;
        exp_valid = en && vld;
        if (en && vld) begin
            for (int k = 0; k < NL; k++) begin
                s = m_map[k];
                d = m_delay[s];
                if (d == 0)
                    exp_data[(NL-1-k)*NBD +: NBD] = lane_of(last_in, s);
                else if (m_fill < d)
                    exp_data[(NL-1-k)*NBD +: NBD] = '0;
                else
                    exp_data[(NL-1-k)*NBD +: NBD] = lane_of(hist[hcnt-d], s);
            end
            if (hcnt < HMAX) hist[hcnt] = last_in;
            hcnt++;
            if (m_fill < 31) m_fill++;
        end
        if (load) begin
            legal = 1'b1;
            for (int j = 0; j < 32; j++) seen[j] = 1'b0;
            for (int k = 0; k < NL; k++) begin
                if (cfg_map[k] < 0 || cfg_map[k] >= NL) legal = 1'b0;
                else if (seen[cfg_map[k]]) legal = 1'b0;
                else seen[cfg_map[k]] = 1'b1;
            end
            if (legal) begin
                for (int k = 0; k < NL; k++) begin
                    m_map[k]   = cfg_map[k];
                    m_delay[k] = cfg_delay[k];
                end
                m_fill  = 0;
                exp_err = 1'b0;
            end else begin
                exp_err = 1'b1;
            end
        end
        exp_busy = (m_fill < max_delay());
        @(negedge i_clock);
        i_cfg_load = 1'b0;
    endtask

    task automatic do_reset(input bit load);
        i_reset    = 1'b1;
        i_enable   = 1'b1;
        i_valid    = 1'b1;
        i_cfg_load = load;
        @(posedge i_clock);
        set_model_defaults();
        @(negedge i_clock);
        i_reset    = 1'b0;
        i_cfg_load = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(1'b0);
        tests++;
        if (o_data !== '0 || o_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_data: got valid %b lane0 %h want valid 0 data 0", o_valid, lane_of(o_data, 0));
        end
        tests++;
        if ({o_cfg_busy, o_lane_map_err} !== 2'b10) begin
            fails++;
            $display("FAIL reset_status: busy/err got %b%b want 10", o_cfg_busy, o_lane_map_err);
        end
    endtask

    task automatic test_default_fill();
        int nv = 0;
        bit vld;
        int l;
        for (int i = 0; i < 45; i++) begin
            vld = ($urandom_range(0, 3) != 0);
            cycle(1'b1, vld, 1'b0);
            if (vld) nv++;
            tests++;
            if (o_data !== exp_data || o_valid !== exp_valid) begin
                fails++;
                l = diff_lane(o_data, exp_data);
                $display("FAIL default_fill cyc %0d lane %0d: got %h/%b want %h/%b", i, l, lane_of(o_data, l), o_valid, lane_of(exp_data, l), exp_valid);
            end
            tests++;
            if ({o_cfg_busy, o_lane_map_err} !== {exp_busy, exp_err}) begin
                fails++;
                $display("FAIL default_fill_status cyc %0d: got %b%b want %b%b", i, o_cfg_busy, o_lane_map_err, exp_busy, exp_err);
            end
            if (vld && (nv == 18 || nv == 19)) begin
                tests++;
                if (o_cfg_busy !== (nv == 18)) begin
                    fails++;
                    $display("FAIL default_busy_edge valids %0d: got %b want %b", nv, o_cfg_busy, nv == 18);
                end
            end
        end
    endtask

    task automatic test_reverse_map();
        int l;
        for (int k = 0; k < NL; k++) begin
            cfg_delay[k] = 0;
            cfg_map[k]   = NL - 1 - k;
        end
        cycle(1'b1, 1'b0, 1'b1);
        tests++;
        if ({o_cfg_busy, o_lane_map_err} !== 2'b00) begin
            fails++;
            $display("FAIL reverse_load_status: got %b%b want 00", o_cfg_busy, o_lane_map_err);
        end
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, ($urandom_range(0, 2) != 0), 1'b0);
            tests++;
            if (o_data !== exp_data || o_valid !== exp_valid) begin
                fails++;
                l = diff_lane(o_data, exp_data);
                $display("FAIL reverse_map cyc %0d lane %0d: got %h want %h", i, l, lane_of(o_data, l), lane_of(exp_data, l));
            end
            if (exp_valid) begin
                tests++;
                if (lane_of(o_data, 0) !== lane_of(last_in, 19)) begin
                    fails++;
                    $display("FAIL reverse_lane0 cyc %0d: got %h want %h", i, lane_of(o_data, 0), lane_of(last_in, 19));
                end
            end
        end
    endtask

    task automatic test_max_delay();
        int l;
        for (int k = 0; k < NL; k++) begin
            cfg_delay[k] = (k == 3) ? 31 : 0;
            cfg_map[k]   = k;
        end
        cycle(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 90; i++) begin
            cycle(1'b1, ($urandom_range(0, 4) != 0), 1'b0);
            tests++;
            if (o_data !== exp_data || {o_valid, o_cfg_busy} !== {exp_valid, exp_busy}) begin
                fails++;
                l = diff_lane(o_data, exp_data);
                $display("FAIL max_delay cyc %0d lane %0d: got %h/%b%b want %h/%b%b", i, l, lane_of(o_data, l), o_valid, o_cfg_busy, lane_of(exp_data, l), exp_valid, exp_busy);
            end
        end
    endtask

    task automatic test_illegal_maps();
        int l;
        cfg_random_perm();
        for (int k = 0; k < NL; k++) cfg_map[k] = NL - 1 - k;
        cycle(1'b1, 1'b1, 1'b1);
        for (int p = 0; p < 3; p++) begin
            cfg_random_perm();
            if (p == 0) cfg_map[4] = 21;
            if (p == 1) begin
                for (int k = 0; k < NL; k++) cfg_map[k] = NL - 1 - k;
                cfg_map[0] = 7;
            end
            cycle(1'b1, 1'b1, 1'b1);
            tests++;
            if (o_lane_map_err !== exp_err) begin
                fails++;
                $display("FAIL illegal_err load %0d: got %b want %b", p, o_lane_map_err, exp_err);
            end
            for (int i = 0; i < 15; i++) begin
                cycle(1'b1, ($urandom_range(0, 3) != 0), 1'b0);
                tests++;
                if (o_data !== exp_data || {o_valid, o_cfg_busy, o_lane_map_err} !== {exp_valid, exp_busy, exp_err}) begin
                    fails++;
                    l = diff_lane(o_data, exp_data);
                    $display("FAIL illegal_stream load %0d cyc %0d lane %0d: got %h/%b%b%b want %h/%b%b%b", p, i, l, lane_of(o_data, l), o_valid, o_cfg_busy, o_lane_map_err, lane_of(exp_data, l), exp_valid, exp_busy, exp_err);
                end
            end
        end
    endtask

    task automatic test_load_with_valid();
        int l;
        cfg_random_perm();
        cycle(1'b1, 1'b1, 1'b1);
        tests++;
        if (o_data !== exp_data || {o_valid, o_cfg_busy} !== {exp_valid, exp_busy}) begin
            fails++;
            l = diff_lane(o_data, exp_data);
            $display("FAIL load_with_valid lane %0d: got %h/%b%b want %h/%b%b", l, lane_of(o_data, l), o_valid, o_cfg_busy, lane_of(exp_data, l), exp_valid, exp_busy);
        end
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, ($urandom_range(0, 3) != 0), 1'b0);
            tests++;
            if (o_data !== exp_data || {o_valid, o_cfg_busy} !== {exp_valid, exp_busy}) begin
                fails++;
                l = diff_lane(o_data, exp_data);
                $display("FAIL load_with_valid_stream cyc %0d lane %0d: got %h want %h", i, l, lane_of(o_data, l), lane_of(exp_data, l));
            end
        end
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, i[0], 1'b0);
            tests++;
            if (o_data !== exp_data || o_valid !== 1'b0) begin
                fails++;
                l = diff_lane(o_data, exp_data);
                $display("FAIL enable_low cyc %0d lane %0d: got %h/%b want %h/0", i, l, lane_of(o_data, l), o_valid, lane_of(exp_data, l));
            end
        end
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b1, 1'b0);
            tests++;
            if (o_data !== exp_data || o_valid !== exp_valid) begin
                fails++;
                l = diff_lane(o_data, exp_data);
                $display("FAIL enable_resume cyc %0d lane %0d: got %h want %h", i, l, lane_of(o_data, l), lane_of(exp_data, l));
            end
        end
    endtask

    task automatic test_back_to_back();
        int l;
        for (int p = 0; p < 2; p++) begin
            cfg_random_perm();
            cycle(1'b1, $urandom_range(0, 1) == 1, 1'b1);
            cfg_random_perm();
            if (p == 1) cfg_map[5] = cfg_map[6];
            cycle(1'b1, $urandom_range(0, 1) == 1, 1'b1);
            tests++;
            if ({o_cfg_busy, o_lane_map_err} !== {exp_busy, exp_err}) begin
                fails++;
                $display("FAIL back_to_back_status pair %0d: got %b%b want %b%b", p, o_cfg_busy, o_lane_map_err, exp_busy, exp_err);
            end
            for (int i = 0; i < 40; i++) begin
                cycle(1'b1, ($urandom_range(0, 3) != 0), 1'b0);
                tests++;
                if (o_data !== exp_data || {o_valid, o_cfg_busy} !== {exp_valid, exp_busy}) begin
                    fails++;
                    l = diff_lane(o_data, exp_data);
                    $display("FAIL back_to_back pair %0d cyc %0d lane %0d: got %h want %h", p, i, l, lane_of(o_data, l), lane_of(exp_data, l));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int nv = 0;
        int l;
        do_reset(1'b0);
        while (nv < 40) begin
            cycle(1'b1, 1'b1, 1'b0);
            nv++;
        end
        cfg_random_perm();
        do_reset(1'b1);
        tests++;
        if (o_data !== '0 || {o_valid, o_cfg_busy, o_lane_map_err} !== 3'b010) begin
            fails++;
            $display("FAIL reset_mid: got lane0 %h flags %b%b%b want 0 flags 010", lane_of(o_data, 0), o_valid, o_cfg_busy, o_lane_map_err);
        end
        for (int i = 0; i < 30; i++) begin
            cycle(1'b1, 1'b1, 1'b0);
            tests++;
            if (o_data !== exp_data || {o_valid, o_cfg_busy} !== {exp_valid, exp_busy}) begin
                fails++;
                l = diff_lane(o_data, exp_data);
                $display("FAIL reset_mid_stream cyc %0d lane %0d: got %h/%b want %h/%b", i, l, lane_of(o_data, l), o_cfg_busy, lane_of(exp_data, l), exp_busy);
            end
        end
    endtask

    initial begin
        i_reset     = 1'b0;
        i_enable    = 1'b0;
        i_valid     = 1'b0;
        i_cfg_load  = 1'b0;
        i_data      = '0;
        i_delay_cfg = '0;
        i_lane_map  = '0;
        for (int k = 0; k < NL; k++) begin
            cfg_delay[k] = 0;
            cfg_map[k]   = k;
        end
        set_model_defaults();
        test_reset();
        test_default_fill();
        test_reverse_map();
        test_max_delay();
        test_illegal_maps();
        test_load_with_valid();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lane_skew_emulator.md
Name: lane_skew_emulator

Overview:
- Runtime-programmable multi-lane skew and lane-reorder emulator for the TX→RX PCS path.
- Sits after AM insertion and ahead of the RX lane deskew/reorder logic.
- Replaces fixed per-lane compile-time delay chains with per-lane programmable block delays and a lane permutation.
- Applies staged config atomically, zero-fills during warm-up, and rejects illegal lane maps.

Parameters:
- NB_DATA_CODED, 66, bits per coded block per lane
- N_LANES, 20, number of PCS lanes
- NB_DELAY, 5, delay field width; max delay 2**NB_DELAY-1 blocks; ring depth 2**NB_DELAY
- NB_LANE_ID, 5, lane-index field width; must satisfy 2**NB_LANE_ID >= N_LANES

Ports:
- i_clock, in, 1, clock
- i_reset, in, 1, reset
- i_enable, in, 1, block enable
- i_valid, in, 1, input block strobe (slow valid)
- i_data, in, NB_DATA_CODED*N_LANES, lane 0 in MSB slice
- i_delay_cfg, in, NB_DELAY*N_LANES, staged per-input-lane delay in blocks; lane 0 in MSB slice
- i_lane_map, in, NB_LANE_ID*N_LANES, staged map; slice k = source input lane for output lane k; lane 0 in MSB slice
- i_cfg_load, in, 1, single-cycle pulse; validates and applies staged config
- o_data, out, NB_DATA_CODED*N_LANES, skewed/reordered lanes
- o_valid, out, 1, output strobe
- o_cfg_busy, out, 1, high while any lane is still zero-filling
- o_lane_map_err, out, 1, sticky: last load rejected

Behaviour:
- Reset i_reset, synchronous, active-high; clock i_clock.
- Reset values:
  - o_data=0, o_valid=0, o_lane_map_err=0.
  - wr_ptr=0, fill_cnt=0.
  - Active map = identity.
  - Active delay[j] = j mod 2**NB_DELAY.
  - o_cfg_busy=1 if any default delay > 0.
- Ring memories are not reset; zero-fill is controlled by fill_cnt only.
- Advance condition: adv = i_enable && i_valid.
- On adv, per input lane s:
  - Write i_data slice s into ring_s[wr_ptr]; wr_ptr increments mod 2**NB_DELAY.
  - fill_cnt increments, saturating at 2**NB_DELAY-1.
- Output on adv, per output lane k, registered:
  - Let s = map[k] and d = delay[s].
  - If d == 0: o_data lane k = current i_data slice s.
  - Else if fill_cnt < d: o_data lane k = 0.
  - Else: o_data lane k = ring_s[(wr_ptr - d) mod 2**NB_DELAY], read before this cycle's write.
  - Net effect: output is the block of lane s from d valids earlier.
  - Latency: 1 clock from adv to o_data/o_valid.
  - o_valid = registered adv.
  - Width rule: pointer subtraction is NB_DELAY-bit modulo arithmetic.
- When adv=0: wr_ptr, fill_cnt and o_data hold; o_valid=0.
- i_enable=0: no writes or reads, everything holds, o_valid=0. i_cfg_load is still accepted.
- Map validation on i_cfg_load (combinational check):
  - Illegal if any entry >= N_LANES or any two entries are equal.
  - Illegal load: active config unchanged, o_lane_map_err=1 next cycle, fill_cnt untouched.
  - Legal load: delay and map copied to active registers next cycle, fill_cnt cleared to 0, o_lane_map_err cleared.
- i_cfg_load coincident with adv:
  - That block is processed entirely with the old config.
  - fill_cnt clears after this cycle's increment (load wins).
  - The new config governs from the next adv.
- o_cfg_busy = (fill_cnt < max active delay), registered; it drops on the cycle after the settling adv.
- Back-to-back i_cfg_load: each pulse is evaluated independently and the last legal one wins.
- Reset mid-operation restores all reset values in one cycle; a simultaneous i_cfg_load is ignored.

Decomposition:
- Package lane_skew_pkg:
  - Constant ring depth (2**NB_DELAY).
  - Zero-fill constant.
  - Function for identity-map default.
  - Function for default-delay vector (j mod depth).
- Sub-module lane_delay_ring (one instance per lane):
  - Ports: write enable, wr_ptr, read address, write data, read data.
  - Single-write/single-read ring, inferable as distributed RAM.
- Top level owns:
  - wr_ptr and fill_cnt.
  - Config shadow/active registers and validation.
  - Output crossbar (N_LANES x N_LANES mux) and output registers.

Test Plan:
- Reset defaults, N_LANES=20, NB_DELAY=5; lane j input = {j, valid index}:
  - Output lane 5 is 0 for the first 5 valids, then carries lane 5 block n-5.
  - o_cfg_busy falls after the 19th valid.
- Load delays all 0, map reversed (k → 19-k):
  - On the next valid, o_data lane 0 = current input lane 19 with latency 1 clock.
  - o_cfg_busy=0, o_lane_map_err=0.
- Load delay lane 3 = 31, others 0:
  - Output lane 3 is 0 for 31 valids, then the block from 31 valids earlier.
  - wr_ptr wraps without corrupting data.
- Load map with entry 21, then a map with duplicate entry 7:
  - Both rejected; o_lane_map_err=1; previous mapping and data continuity unaffected.
  - A following legal load clears the error.
- i_cfg_load on the same cycle as i_valid:
  - That block output uses the old map/delay; fill_cnt=0 afterwards.
  - i_enable low for 10 cycles with i_valid toggling: o_valid=0 and o_data frozen.
- Assert i_reset mid-stream after 40 valids:
  - Next cycle: o_data=0, o_valid=0, identity map, default delays, fill restarts from 0.
